vx_tex_mem_slave: RTL
=====================

// Module: vx_tex_mem_slave
// PURPOSE
//  Memory-side responder for the texture unit's cache request bus. It serves NUM_PORTS request
//  channels from a single-ported on-chip texel SRAM. Channels are arbitrated round-robin and each
//  channel has its own credit-limited in-order response queue. It stands in for the texture cache
//  in the tex subsystem bench and in small configs without a tcache.
// PARAMETERS
//  NUM_PORTS    4    request/response channels (>=1)
//  ADDR_WIDTH   16   word address width (32-bit words)
//  TAG_WIDTH    8    request tag width, returned unchanged
//  SIZE_WORDS   1024 SRAM depth, power of 2; index = addr[log2(SIZE_WORDS)-1:0], upper bits ignored
//  LATENCY      2    read latency in cycles, grant to rsp_valid (>=1)
//  QUEUE_SIZE   4    max outstanding reads per port (pipe + queue), power of 2
// PORTS
//  clk             in   1                        clock
//  reset           in   1                        synchronous, active-high
//  req_valid       in   NUM_PORTS                request valid per port
//  req_rw          in   NUM_PORTS                1 = write, 0 = read
//  req_addr        in   NUM_PORTS*ADDR_WIDTH     word address
//  req_byteen      in   NUM_PORTS*4              write byte enables
//  req_data        in   NUM_PORTS*32             write data
//  req_tag         in   NUM_PORTS*TAG_WIDTH      request tag
//  req_ready       out  NUM_PORTS                request accepted this cycle
//  rsp_valid       out  NUM_PORTS                read response valid
//  rsp_data        out  NUM_PORTS*32             read data
//  rsp_tag         out  NUM_PORTS*TAG_WIDTH      tag of the matching request
//  rsp_ready       in   NUM_PORTS                response consumed
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
//  - Reset: req_ready=0, rsp_valid=0, credits=0, RR pointer=port 0, pipeline and queues flushed.
//    In-flight reads are dropped. SRAM contents are preserved, not initialised.
//  - Eligibility: port i is eligible if req_valid[i] && (rw[i] || credit[i] < QUEUE_SIZE).
//  - Arbitration: one grant per cycle, round-robin over eligible ports, starting from the port
//    after the last grant. req_ready[i] = grant[i]; it is combinational on req_valid and credit.
//  - Writes: SRAM is updated at the grant edge under byteen. No response; no credit consumed.
//  - Reads: SRAM is read at grant. Data and tag travel LATENCY stages into the port's FWFT queue.
//    rsp_valid rises exactly LATENCY cycles after the handshake cycle if the queue was empty.
//  - Ordering: responses are in order per port. No ordering across ports.
//  - Credits: +1 on read grant, -1 on rsp fire; both in one cycle = unchanged. A queue never
//    overflows, so rsp_ready may stay low indefinitely; that port then stalls at QUEUE_SIZE.
//  - Hazards: writes and reads are serialised through the single grant. A read granted the cycle
//    after a write to the same word returns the written data. A same-cycle conflict cannot occur.
//  - Response output: rsp_data/rsp_tag hold stable while rsp_valid && !rsp_ready.
// CONFIGURATION
//  TEX_MEM_SLAVE_PERF_EN defined: adds outputs perf_reads[31:0], perf_writes[31:0],
//    perf_stalls[31:0].
//    - perf_reads, perf_writes: count accepted reads and writes.
//    - perf_stalls: counts cycles with any req_valid[i] && !req_ready[i].
//    - All counters reset to 0 and wrap at 2^32.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Write 0xDEADBEEF to addr 5 (byteen 4'b1111), then read addr 5 tag 0x3C on port 0 ->
//     rsp_valid[0] 2 cycles after read accept, data 0xDEADBEEF, tag 0x3C.
//  2. Write 0x11223344, then write 0xAABBCCDD with byteen 4'b0101 to the same addr, read back ->
//     0x11BB33DD.
//  3. All 4 ports issue a read every cycle, rsp_ready=1 -> grants rotate 0,1,2,3,0...
//     Each port gets 1 grant per 4 cycles. No response is lost; tags return in order per port.
//  4. Port 2 rsp_ready=0, issue 6 reads -> 4 accepted, then req_ready[2]=0.
//     Raise rsp_ready -> remaining 2 accepted. All 6 tags return in issue order.
//  5. Read addr 0x0405 with SIZE_WORDS=1024 -> returns the word at index 5 (upper bits ignored).
//  6. Assert reset with 3 reads in flight -> next cycle rsp_valid=0 and credits=0.
//     A read of previously written data after reset still returns that data.
//     With PERF_EN, perf_reads=1 after that single post-reset read.

Source files
------------

// File: rtl/vx_tex_mem_slave.sv
// Multi-port texel memory responder: round-robin grant into a single-ported SRAM, shared read
// pipeline, per-port credit-limited FWFT response queues. Define TEX_MEM_SLAVE_PERF_EN for perf counters.
module vx_tex_mem_slave #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int SIZE_WORDS = 1024,
  parameter int LATENCY    = 2,
  parameter int QUEUE_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS-1:0]           req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*4-1:0]         req_byteen,
  input  logic [NUM_PORTS*32-1:0]        req_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           rsp_valid,
  output logic [NUM_PORTS*32-1:0]        rsp_data,
  output logic [NUM_PORTS*TAG_WIDTH-1:0] rsp_tag,
  input  logic [NUM_PORTS-1:0]           rsp_ready
`ifdef TEX_MEM_SLAVE_PERF_EN
  ,
  output logic [31:0]                    perf_reads,
  output logic [31:0]                    perf_writes,
  output logic [31:0]                    perf_stalls
`endif
);

  localparam int IW   = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int QW   = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CW   = $clog2(QUEUE_SIZE + 1);
  localparam int LAST = LATENCY - 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(QUEUE_SIZE);

  logic [31:0]           mem [SIZE_WORDS];

  logic [PW-1:0]         rr_ptr;
  logic [CW-1:0]         credit [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  grant;
  logic                  gnt_any;
  logic [PW-1:0]         gnt_idx;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [IW-1:0]         sel_idx;
  logic [3:0]            sel_byteen;
  logic [31:0]           sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  unused_addr;

  logic                  vld_p  [LATENCY];
  logic [31:0]           data_p [LATENCY];
  logic [TAG_WIDTH-1:0]  tag_p  [LATENCY];
  logic [PW-1:0]         port_p [LATENCY];

  logic [31:0]           q_data [NUM_PORTS][QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  q_tag  [NUM_PORTS][QUEUE_SIZE];
  logic [QW-1:0]         q_rd   [NUM_PORTS];
  logic [QW-1:0]         q_wr   [NUM_PORTS];
  logic [CW-1:0]         q_cnt  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  last_hit;
  logic [NUM_PORTS-1:0]  q_push;
  logic [NUM_PORTS-1:0]  q_pop;
  logic [NUM_PORTS-1:0]  rsp_fire;

  // Credits count reads in the pipe plus the queue, so the queue can never overflow.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_valid[i] && (req_rw[i] || (credit[i] < CREDIT_MAX));
    end
  end

  always_comb begin
    logic [PW-1:0] p;
    p       = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      p = PW'((int'(rr_ptr) + off) % NUM_PORTS);
      if (!gnt_any && !reset && eligible[p]) begin
        gnt_any = 1'b1;
        gnt_idx = p;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign req_ready   = grant;
  assign sel_addr    = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_idx     = sel_addr[IW-1:0];
  assign sel_byteen  = req_byteen[int'(gnt_idx)*4 +: 4];
  assign sel_data    = req_data[int'(gnt_idx)*32 +: 32];
  assign sel_tag     = req_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
  assign rd_fire     = gnt_any && !req_rw[gnt_idx];
  assign wr_fire     = gnt_any && req_rw[gnt_idx];
  assign unused_addr = ^sel_addr;

  // Stage p0: SRAM access at the grant edge; later stages only delay data and tag.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_byteen[b]) mem[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
    if (rd_fire) begin
      data_p[0] <= mem[sel_idx];
      tag_p[0]  <= sel_tag;
      port_p[0] <= gnt_idx;
    end
    for (int k = 1; k < LATENCY; k++) begin
      data_p[k] <= data_p[k-1];
      tag_p[k]  <= tag_p[k-1];
      port_p[k] <= port_p[k-1];
    end
  end

  // Last stage bypasses an empty queue so an unstalled read shows up exactly LATENCY cycles after grant.
  always_comb begin
    last_hit  = '0;
    q_push    = '0;
    q_pop     = '0;
    rsp_valid = '0;
    rsp_fire  = '0;
    rsp_data  = '0;
    rsp_tag   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      last_hit[i]  = vld_p[LAST] && (port_p[LAST] == PW'(i));
      q_pop[i]     = (q_cnt[i] != '0) && rsp_ready[i];
      q_push[i]    = last_hit[i] && !((q_cnt[i] == '0) && rsp_ready[i]);
      rsp_valid[i] = !reset && ((q_cnt[i] != '0) || last_hit[i]);
      rsp_fire[i]  = !reset && ((q_cnt[i] != '0) || last_hit[i]) && rsp_ready[i];
      if (q_cnt[i] != '0) begin
        rsp_data[i*32 +: 32]              = q_data[i][q_rd[i]];
        rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] = q_tag[i][q_rd[i]];
      end else begin
        rsp_data[i*32 +: 32]              = data_p[LAST];
        rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] = tag_p[LAST];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (q_push[i]) begin
        q_data[i][q_wr[i]] <= data_p[LAST];
        q_tag[i][q_wr[i]]  <= tag_p[LAST];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int k = 0; k < LATENCY; k++) vld_p[k] <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit[i] <= '0;
        q_cnt[i]  <= '0;
        q_rd[i]   <= '0;
        q_wr[i]   <= '0;
      end
    end else begin
      if (gnt_any) rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      vld_p[0] <= rd_fire;
      for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit[i] <= credit[i] + CW'(grant[i] && !req_rw[i]) - CW'(rsp_fire[i]);
        q_cnt[i]  <= q_cnt[i] + CW'(q_push[i]) - CW'(q_pop[i]);
        if (q_push[i]) q_wr[i] <= (q_wr[i] == QW'(QUEUE_SIZE - 1)) ? '0 : q_wr[i] + 1'b1;
        if (q_pop[i])  q_rd[i] <= (q_rd[i] == QW'(QUEUE_SIZE - 1)) ? '0 : q_rd[i] + 1'b1;
      end
    end
  end

`ifdef TEX_MEM_SLAVE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire) perf_reads <= perf_reads + 32'd1;
      if (wr_fire) perf_writes <= perf_writes + 32'd1;
      if (|(req_valid & ~grant)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
